// File: rtl/router_reg_param.sv
// Router packet register stage: header capture, dout mux, hold buffer, parity check.
// Optional LEN_CHECK_EN adds len_err (payload count vs header length field).
module router_reg_param #(
  parameter int DATA_W     = 8,
  parameter int HOLD_DEPTH = 2,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic [3:0]        hold_cnt,
  output logic              hold_ovf,
  output logic [CNT_W-1:0]  pay_cnt
`ifdef LEN_CHECK_EN
  ,
  output logic              len_err
`endif
);

  localparam int PW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;

  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] par_q, par_d;
  logic [DATA_W-1:0] ppar_q, ppar_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              pd_q, pd_d;
  logic              lpv_q, lpv_d;
  logic              err_q, err_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  pay_q, pay_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic              len_q, len_d;
  logic [DATA_W-1:0] hold_q [HOLD_DEPTH];

  logic hdr_ld, acc, push, hfull, wr_en, ld_out, pop_en, len_bad;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(HOLD_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign hdr_ld = detect_add & pkt_valid;
  assign acc    = ld_state & pkt_valid & ~full_state;
  assign push   = ld_state & fifo_full;
  assign hfull  = (cnt_q == 4'(HOLD_DEPTH));
  assign wr_en  = push & ~hfull;
  assign ld_out = ld_state & ~fifo_full;
  // A pop only happens when the hold buffer wins the dout mux
  assign pop_en = ~lfd_state & ~ld_out & laf_state
                & (cnt_q != 4'd0) & ~fifo_full;

`ifdef LEN_CHECK_EN
  assign len_bad = (32'(pay_q) != 32'(hdr_q[DATA_W-1:2]));
`else
  assign len_bad = 1'b0;
`endif

  always_comb begin
    hdr_d  = hdr_q;
    par_d  = par_q;
    ppar_d = ppar_q;
    dout_d = dout_q;
    vld_d  = 1'b0;
    pd_d   = pd_q;
    lpv_d  = lpv_q;
    ovf_d  = ovf_q;
    pay_d  = pay_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    len_d  = len_q;
    cnt_d  = cnt_q + {3'b0, wr_en} - {3'b0, pop_en};
    if (hdr_ld) begin
      hdr_d = data_in;
      par_d = '0;
      pay_d = '0;
    end else if (lfd_state) begin
      par_d = par_q ^ hdr_q;
    end else if (acc) begin
      par_d = par_q ^ data_in;
      if (pay_q != '1) pay_d = pay_q + CNT_W'(1);
    end
    if (ld_state & ~pkt_valid) begin
      ppar_d = data_in;
      lpv_d  = 1'b1;
    end else if (rst_int_reg) begin
      lpv_d  = 1'b0;
    end
    if (lfd_state) begin
      dout_d = hdr_q;
      vld_d  = 1'b1;
    end else if (ld_out) begin
      dout_d = data_in;
      vld_d  = 1'b1;
    end else if (pop_en) begin
      dout_d = hold_q[rd_q];
      vld_d  = 1'b1;
    end
    if (wr_en)  wr_d = nxt(wr_q);
    if (pop_en) rd_d = nxt(rd_q);
    if (push & hfull)   ovf_d = 1'b1;
    else if (detect_add) ovf_d = 1'b0;
    if (detect_add)
      pd_d = 1'b0;
    else if (ld_out & ~pkt_valid)
      pd_d = 1'b1;
    else if (laf_state & lpv_q & (cnt_q == 4'd0) & ~pd_q)
      pd_d = 1'b1;
    if (detect_add)          len_d = 1'b0;
    else if (pd_d & ~pd_q)   len_d = len_bad;
    err_d = pd_q & ((par_q != ppar_q) | ovf_q | len_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q  <= '0;
      par_q  <= '0;
      ppar_q <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      pd_q   <= 1'b0;
      lpv_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      pay_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      len_q  <= 1'b0;
      for (int i = 0; i < HOLD_DEPTH; i++) hold_q[i] <= '0;
    end else begin
      hdr_q  <= hdr_d;
      par_q  <= par_d;
      ppar_q <= ppar_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      pd_q   <= pd_d;
      lpv_q  <= lpv_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      pay_q  <= pay_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      len_q  <= len_d;
      if (wr_en) hold_q[wr_q] <= data_in;
    end
  end

  assign dout          = dout_q;
  assign dout_vld      = vld_q;
  assign parity_done   = pd_q;
  assign low_pkt_valid = lpv_q;
  assign err           = err_q;
  assign hold_cnt      = cnt_q;
  assign hold_ovf      = ovf_q;
  assign pay_cnt       = pay_q;
`ifdef LEN_CHECK_EN
  assign len_err       = len_q;
`endif

endmodule

// File: tb/tb_router_reg_param.sv
// Bench for router_reg_param: vector table, directed hold/overflow/reset
// sequences and random packets against a packet-level model.
module tb_router_reg_param;

  localparam int HD = 2;

  logic       clk = 1'b0;
  logic       rst, pkt_valid, fifo_full, detect_add, lfd_state;
  logic       ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] data_in, dout;
  logic       dout_vld, parity_done, low_pkt_valid, err, hold_ovf;
  logic [3:0] hold_cnt;
  logic [5:0] pay_cnt;
`ifdef LEN_CHECK_EN
  logic       len_err;
`endif

  int n_run  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] pl [16];
  bit         fl [17];

  always #5 clk = ~clk;

  router_reg_param #(.DATA_W(8), .HOLD_DEPTH(HD), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .dout_vld(dout_vld),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .err(err), .hold_cnt(hold_cnt), .hold_ovf(hold_ovf),
    .pay_cnt(pay_cnt)
`ifdef LEN_CHECK_EN
    , .len_err(len_err)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    pkt_valid = 0; fifo_full = 0; detect_add = 0; lfd_state = 0;
    ld_state = 0; laf_state = 0; full_state = 0; rst_int_reg = 0;
    data_in = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every FIFO write must match the next byte the model expects
  always @(posedge clk) begin
    #1;
    if (mon_en && dout_vld) begin
      if (exp_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL dout_extra: got %0h expected no write", dout);
      end else begin
        chk("dout_stream", dout, exp_q.pop_front());
      end
    end
  end

  task automatic run_pkt(input logic [7:0] hdr, input int n,
                         input bit corrupt);
    logic [7:0] par, pb, b;
    bit ovf, perr, lbad;
    int i, run, drn;
    par = hdr;
    for (int k = 0; k < n; k++) par ^= pl[k];
    pb = corrupt ? (par ^ 8'h01) : par;
    ovf = 0;
    exp_q.delete();
    exp_q.push_back(hdr);
    mon_en = 1'b1;
    idle(); detect_add = 1; pkt_valid = 1; data_in = hdr; step();
    chk("hdr_ovf_clear", hold_ovf, 0);
    chk("hdr_pay_clear", pay_cnt, 0);
    idle(); lfd_state = 1; pkt_valid = 1; step();
    i = 0;
    while (i <= n) begin
      if (!fl[i]) begin
        b = (i < n) ? pl[i] : pb;
        exp_q.push_back(b);
        idle(); ld_state = 1; pkt_valid = (i < n); data_in = b;
        step();
        i++;
      end else begin
        run = 0;
        while (i <= n && fl[i]) begin
          b = (i < n) ? pl[i] : pb;
          if (run < HD) exp_q.push_back(b);
          else ovf = 1;
          idle(); ld_state = 1; fifo_full = 1;
          pkt_valid = (i < n); data_in = b;
          step();
          run++;
          i++;
          chk("hold_fill", hold_cnt, (run < HD) ? run : HD);
          chk("hold_ovf_run", hold_ovf, ovf);
        end
        idle(); full_state = 1; fifo_full = 1; step();
        drn = (run < HD) ? run : HD;
        for (int k = 0; k < drn; k++) begin
          idle(); laf_state = 1; step();
          chk("hold_drain", hold_cnt, drn - 1 - k);
        end
        if (i > n) begin
          idle(); laf_state = 1; step();
        end
      end
    end
    chk("parity_done", parity_done, 1);
    idle(); step();
    perr = (pb != par);
    lbad = 0;
`ifdef LEN_CHECK_EN
    lbad = (n != int'(hdr[7:2]));
    chk("len_err", len_err, lbad);
`endif
    chk("err", err, perr | ovf | lbad);
    chk("pay_cnt", pay_cnt, n);
    chk("hold_ovf_end", hold_ovf, ovf);
    chk("hold_cnt_end", hold_cnt, 0);
    chk("stream_left", exp_q.size(), 0);
    idle(); rst_int_reg = 1; step();
    idle();
    chk("lpv_clear", low_pkt_valid, 0);
  endtask

  typedef struct {
    logic       da, lfd, ld, pv;
    logic [7:0] din, e_dout;
    logic       e_vld, e_pd, e_err;
    logic [5:0] e_pay;
  } vec_t;

  vec_t tbl[14];

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_pd", parity_done, 0);
    chk("rst_lpv", low_pkt_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_hold", hold_cnt, 0);
    chk("rst_ovf", hold_ovf, 0);
    chk("rst_pay", pay_cnt, 0);

    // Two packets 0D,11,22,33: good parity 0D, then corrupted 0C
    tbl[0]  = '{1,0,0,1,8'h0D,8'h00,0,0,0,0};
    tbl[1]  = '{0,1,0,1,8'h11,8'h0D,1,0,0,0};
    tbl[2]  = '{0,0,1,1,8'h11,8'h11,1,0,0,1};
    tbl[3]  = '{0,0,1,1,8'h22,8'h22,1,0,0,2};
    tbl[4]  = '{0,0,1,1,8'h33,8'h33,1,0,0,3};
    tbl[5]  = '{0,0,1,0,8'h0D,8'h0D,1,1,0,3};
    tbl[6]  = '{0,0,0,0,8'h00,8'h0D,0,1,0,3};
    tbl[7]  = '{1,0,0,1,8'h0D,8'h0D,0,0,0,0};
    tbl[8]  = '{0,1,0,1,8'h11,8'h0D,1,0,0,0};
    tbl[9]  = '{0,0,1,1,8'h11,8'h11,1,0,0,1};
    tbl[10] = '{0,0,1,1,8'h22,8'h22,1,0,0,2};
    tbl[11] = '{0,0,1,1,8'h33,8'h33,1,0,0,3};
    tbl[12] = '{0,0,1,0,8'h0C,8'h0C,1,1,0,3};
    tbl[13] = '{0,0,0,0,8'h00,8'h0C,0,1,1,3};
    for (int i = 0; i < 14; i++) begin
      idle();
      detect_add = tbl[i].da; lfd_state = tbl[i].lfd;
      ld_state = tbl[i].ld; pkt_valid = tbl[i].pv;
      data_in = tbl[i].din;
      step();
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
      chk($sformatf("tbl%0d_vld", i), dout_vld, tbl[i].e_vld);
      chk($sformatf("tbl%0d_pd", i), parity_done, tbl[i].e_pd);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
      chk($sformatf("tbl%0d_pay", i), pay_cnt, tbl[i].e_pay);
    end

    // low_pkt_valid: set beats clear, then clear alone
    idle(); ld_state = 1; data_in = 8'hAA; rst_int_reg = 1; step();
    chk("lpv_set_wins", low_pkt_valid, 1);
    idle(); rst_int_reg = 1; step();
    chk("lpv_clear_only", low_pkt_valid, 0);
    idle();

    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    for (int k = 0; k < 17; k++) fl[k] = 0;
    fl[0] = 1; fl[1] = 1;
    run_pkt(8'h0D, 3, 0);
    fl[2] = 1;
    run_pkt(8'h0D, 3, 0);

    // Reset in the middle of a payload with a byte held
    mon_en = 1'b0;
    idle(); detect_add = 1; pkt_valid = 1; data_in = 8'h0D; step();
    idle(); lfd_state = 1; pkt_valid = 1; step();
    idle(); ld_state = 1; pkt_valid = 1; data_in = 8'h11; step();
    idle(); ld_state = 1; pkt_valid = 1; fifo_full = 1;
    data_in = 8'h22; step();
    idle(); rst = 1; step();
    rst = 0;
    chk("mrst_zero", {dout, dout_vld, parity_done, low_pkt_valid,
                      err, hold_cnt, hold_ovf, pay_cnt}, 0);
    for (int k = 0; k < 17; k++) fl[k] = 0;
    fl[1] = 1; fl[2] = 1;
    run_pkt(8'h0D, 3, 0);

`ifdef LEN_CHECK_EN
    for (int k = 0; k < 17; k++) fl[k] = 0;
    pl[0] = 8'h5A; pl[1] = 8'hC3;
    run_pkt(8'h0C, 2, 0);
`endif

    for (int p = 0; p < 40; p++) begin
      int n;
      logic [7:0] hdr;
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) pl[k] = 8'($urandom);
      for (int k = 0; k < 17; k++) fl[k] = ($urandom_range(0, 3) == 0);
      hdr = 8'($urandom);
      if ($urandom_range(0, 3) != 0) hdr[7:2] = 6'(n);
      run_pkt(hdr, n, $urandom_range(0, 3) == 0);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
